// File: rtl/enc_pkg.sv
// Shared encoder-link definitions: default geometry, idle timeout and the
// slave FSM state encoding used by the SSI encoder emulator.
package enc_pkg;

    localparam int ENC_DATA_W          = 13;
    localparam int ENC_TIMEOUT_CYC_DEF = 200;

    typedef enum logic [1:0] {
        ST_TIMEOUT = 2'd0,
        ST_READY   = 2'd1,
        ST_SHIFT   = 2'd2
    } enc_state_e;

endpackage : enc_pkg

// File: rtl/sck_sync.sv
// Two-flop synchronizer for an asynchronous serial clock/data line, plus
// single-cycle rise and fall pulses derived from the synchronized level.
// All flops reset to 1 because the line idles high.
module sck_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronize the raw line and keep one cycle of history for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make these three flops a true
            // pipeline; blocking ones would collapse it into a single wire.
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule : sck_sync

// File: rtl/enc_ssi_emulator.sv
// Slave-side SSI encoder emulator. Snapshots pos_in once the link has been
// idle high for TIMEOUT_CYC cycles, then presents the word MSB-first on
// ENC_MISO, changing data only after synchronized SCK rises so it is stable
// at every master falling edge.
module enc_ssi_emulator
    import enc_pkg::*;
#(
    parameter int DATA_W      = ENC_DATA_W,
    parameter int TIMEOUT_CYC = ENC_TIMEOUT_CYC_DEF
) (
    input  logic              CLK_10MHZ,
    input  logic              rst,
    input  logic              ENC_SCK,
    output logic              ENC_MISO,
    input  logic [DATA_W-1:0] pos_in,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int BC_W = $clog2(DATA_W + 1);
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [BC_W-1:0] LAST_FALL = BC_W'(DATA_W - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    logic sck_s;
    logic sck_rise;
    logic sck_fall;

    enc_state_e        state_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic [DATA_W-1:0] shadow_q;
    logic              miso_q;

    sck_sync u_sck_sync (
        .clk_i  (CLK_10MHZ),
        .rst_i  (rst),
        .d_i    (ENC_SCK),
        .q_o    (sck_s),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // Frame FSM: idle timeout, snapshot, bit counting, shifting and the MISO register.
    always_ff @(posedge CLK_10MHZ or posedge rst) begin
        if (rst) begin
            state_q   <= ST_TIMEOUT;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shadow_q  <= '0;
            miso_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_TIMEOUT: begin
                    miso_q <= 1'b0;
                    if (sck_fall) begin
                        // A fall before the link went idle long enough is a protocol error.
                        to_cnt_q <= '0;
                    end else if (sck_s) begin
                        if (to_cnt_q >= TO_LAST) begin
                            shadow_q  <= pos_in;
                            bit_cnt_q <= '0;
                            miso_q    <= pos_in[DATA_W-1];
                            state_q   <= ST_READY;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                end

                ST_READY: begin
                    miso_q <= shadow_q[DATA_W-1];
                    if (sck_fall) begin
                        bit_cnt_q <= BC_W'(1);
                        state_q   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (sck_rise) begin
                        // Master has sampled the current bit; advance after its rise.
                        shadow_q <= {shadow_q[DATA_W-2:0], 1'b0};
                        miso_q   <= shadow_q[DATA_W-2];
                    end else if (sck_fall) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_FALL) begin
                            to_cnt_q <= '0;
                            miso_q   <= 1'b0;
                            state_q  <= ST_TIMEOUT;
                        end
                    end
                end

                default: begin
                    miso_q  <= 1'b0;
                    state_q <= ST_TIMEOUT;
                end
            endcase
        end
    end

    assign ENC_MISO   = miso_q;
    assign busy       = (state_q != ST_TIMEOUT);
    assign frame_done = (state_q == ST_SHIFT) && sck_fall && (bit_cnt_q == LAST_FALL);
    assign frame_err  = (state_q == ST_TIMEOUT) && sck_fall;

endmodule : enc_ssi_emulator
